// File: rtl/fpall_pkg.sv
// Shared FP datapath types for the FP32 / dual-FP16 normalizer: format enum,
// lane geometry, stage beat structs and the per-lane normalize helper.
package fpall_pkg;

  typedef enum logic {
    FP_FMT_FP32 = 1'b0,
    FP_FMT_FP16 = 1'b1
  } fp_fmt_e;

  localparam int FPNORM_W     = 26;
  localparam int FP16_LANE_W  = 10;
  localparam int FP16_GAP_LSB = 10;

  typedef struct packed {
    fp_fmt_e             fmt;
    logic [FPNORM_W-1:0] x;
    logic [7:0]          e_h;
    logic [7:0]          e_l;
  } fpnorm_beat_t;

  typedef struct packed {
    fp_fmt_e             fmt;
    logic [FPNORM_W-1:0] r;
    logic [7:0]          e_h;
    logic [7:0]          e_l;
    logic                zero_h;
    logic                zero_l;
    logic                uf_h;
    logic                uf_l;
  } fpnorm_res_t;

  typedef struct packed {
    logic [FPNORM_W-1:0] r;
    logic [7:0]          e;
    logic                zero;
    logic                uf;
  } lane_res_t;

  // A lane's bits sit right-aligned in x; the shift never exceeds lz, so a
  // 10-bit lane never spills above bit 9.
  function automatic lane_res_t norm_lane(input logic [FPNORM_W-1:0] x,
                                          input logic [7:0] e,
                                          input logic [4:0] lz);
    lane_res_t  res;
    logic [4:0] sh;
    res = '0;
    sh  = 5'd0;
    if (x == 26'd0) begin
      res.zero = 1'b1;
    end else if (e > {3'd0, lz}) begin
      sh    = lz;
      res.e = e - {3'd0, lz};
    end else begin
      sh     = (e == 8'd0) ? 5'd0 : (e[4:0] - 5'd1);
      res.uf = 1'b1;
    end
    res.r = x << sh;
    return res;
  endfunction

endpackage

// File: rtl/fp_normalizer_if.sv
// Valid/ready beat interface of the FP normalizer: input beat plus result beat.
interface fp_normalizer_if;
  import fpall_pkg::*;

  logic                in_valid;
  logic                in_ready;
  fp_fmt_e             in_fmt;
  logic [FPNORM_W-1:0] in_x;
  logic [7:0]          in_e_h;
  logic [7:0]          in_e_l;

  logic                out_valid;
  logic                out_ready;
  fp_fmt_e             out_fmt;
  logic [FPNORM_W-1:0] out_r;
  logic [7:0]          out_e_h;
  logic [7:0]          out_e_l;
  logic                out_zero_h;
  logic                out_zero_l;
  logic                out_uf_h;
  logic                out_uf_l;

  modport master (
    output in_valid, in_fmt, in_x, in_e_h, in_e_l, out_ready,
    input  in_ready, out_valid, out_fmt, out_r, out_e_h, out_e_l,
           out_zero_h, out_zero_l, out_uf_h, out_uf_l
  );

  modport slave (
    input  in_valid, in_fmt, in_x, in_e_h, in_e_l, out_ready,
    output in_ready, out_valid, out_fmt, out_r, out_e_h, out_e_l,
           out_zero_h, out_zero_l, out_uf_h, out_uf_l
  );

endinterface

// File: rtl/fpnorm_lzc.sv
// Segmented leading-zero counter: one 26-bit count for FP32, or two
// independent 10-bit lane counts for FP16 (gap bits ignored).
module fpnorm_lzc
  import fpall_pkg::*;
(
  input  fp_fmt_e             fmt,
  input  logic [FPNORM_W-1:0] x,
  output logic [4:0]          lz_h,
  output logic [4:0]          lz_l
);

  logic [4:0] lz32_s;
  logic [4:0] lzh16_s;
  logic [4:0] lzl16_s;

  // Scan upward so the highest set bit writes last and wins.
  always_comb begin
    lz32_s  = 5'd26;
    lzh16_s = 5'd10;
    lzl16_s = 5'd10;
    for (int i = 0; i < FPNORM_W; i++) begin
      lz32_s = x[i] ? 5'(FPNORM_W - 1 - i) : lz32_s;
    end
    for (int i = 0; i < FP16_LANE_W; i++) begin
      lzl16_s = x[i] ? 5'(FP16_LANE_W - 1 - i) : lzl16_s;
      lzh16_s = x[FPNORM_W - FP16_LANE_W + i] ? 5'(FP16_LANE_W - 1 - i) : lzh16_s;
    end
  end

  // Route the counts by format; FP32 reports on the low lane.
  always_comb begin
    lz_h = 5'd0;
    lz_l = lz32_s;
    case (fmt)
      FP_FMT_FP16: begin
        lz_h = lzh16_s;
        lz_l = lzl16_s;
      end
      FP_FMT_FP32: begin
        lz_h = 5'd0;
        lz_l = lz32_s;
      end
      default: begin
        lz_h = 5'd0;
        lz_l = lz32_s;
      end
    endcase
  end

endmodule

// File: rtl/fp_normalizer.sv
// Two-stage LZC + left-shift normalizer for the shared FP32 / dual-FP16 lane.
// Define FPNORM_OUT_SKID_EN to add a third output stage with a registered in_ready.
module fp_normalizer
  import fpall_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  fp_normalizer_if.slave bus
);

  fpnorm_beat_t in_beat_s;
  fpnorm_beat_t s1_beat_r;
  logic         s1_valid_r;
  logic [4:0]   s1_lz_h_r;
  logic [4:0]   s1_lz_l_r;
  logic [4:0]   lz_h_s;
  logic [4:0]   lz_l_s;
  logic         s2_valid_r;
  fpnorm_res_t  s2_res_r;
  fpnorm_res_t  res_s;
  lane_res_t    lane_h_s;
  lane_res_t    lane_l_s;
  logic         ld1_s;
  logic         ld2_s;
  logic         in_ready_s;
  logic         accept_s;

  assign in_beat_s = '{fmt: bus.in_fmt, x: bus.in_x, e_h: bus.in_e_h, e_l: bus.in_e_l};

  fpnorm_lzc u_lzc (
    .fmt  (bus.in_fmt),
    .x    (bus.in_x),
    .lz_h (lz_h_s),
    .lz_l (lz_l_s)
  );

  // Stage-2 datapath: shift each lane by its own count; FP16 gap stays zero.
  always_comb begin
    res_s     = '0;
    lane_h_s  = '0;
    lane_l_s  = '0;
    res_s.fmt = s1_beat_r.fmt;
    case (s1_beat_r.fmt)
      FP_FMT_FP32: begin
        lane_l_s     = norm_lane(s1_beat_r.x, s1_beat_r.e_l, s1_lz_l_r);
        res_s.r      = lane_l_s.r;
        res_s.e_l    = lane_l_s.e;
        res_s.zero_l = lane_l_s.zero;
        res_s.uf_l   = lane_l_s.uf;
      end
      FP_FMT_FP16: begin
        lane_h_s = norm_lane({16'd0, s1_beat_r.x[FPNORM_W-1 -: FP16_LANE_W]},
                             s1_beat_r.e_h, s1_lz_h_r);
        lane_l_s = norm_lane({16'd0, s1_beat_r.x[FP16_GAP_LSB-1:0]},
                             s1_beat_r.e_l, s1_lz_l_r);
        res_s.r      = {lane_h_s.r[FP16_LANE_W-1:0], 6'd0, lane_l_s.r[FP16_LANE_W-1:0]};
        res_s.e_h    = lane_h_s.e;
        res_s.e_l    = lane_l_s.e;
        res_s.zero_h = lane_h_s.zero;
        res_s.zero_l = lane_l_s.zero;
        res_s.uf_h   = lane_h_s.uf;
        res_s.uf_l   = lane_l_s.uf;
      end
      default: begin
        res_s.fmt = FP_FMT_FP32;
      end
    endcase
  end

`ifdef FPNORM_OUT_SKID_EN
  logic        s3_valid_r;
  fpnorm_res_t s3_res_r;
  logic        in_ready_r;
  logic        ld3_s;
  logic        s1_valid_n_s;
  logic        s2_valid_n_s;
  logic        s3_valid_n_s;

  assign ld3_s        = !s3_valid_r | bus.out_ready;
  assign ld2_s        = !s2_valid_r | ld3_s;
  assign in_ready_s   = in_ready_r;
  assign s1_valid_n_s = ld1_s ? accept_s   : s1_valid_r;
  assign s2_valid_n_s = ld2_s ? s1_valid_r : s2_valid_r;
  assign s3_valid_n_s = ld3_s ? s2_valid_r : s3_valid_r;

  // Any free slot next cycle guarantees the chain can absorb one more beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s3_valid_r <= 1'b0;
      s3_res_r   <= '0;
      in_ready_r <= 1'b1;
    end else begin
      if (ld3_s) begin
        s3_valid_r <= s2_valid_r;
        s3_res_r   <= s2_res_r;
      end
      in_ready_r <= !(s1_valid_n_s & s2_valid_n_s & s3_valid_n_s);
    end
  end

  assign bus.out_valid  = s3_valid_r;
  assign bus.out_fmt    = s3_res_r.fmt;
  assign bus.out_r      = s3_res_r.r;
  assign bus.out_e_h    = s3_res_r.e_h;
  assign bus.out_e_l    = s3_res_r.e_l;
  assign bus.out_zero_h = s3_res_r.zero_h;
  assign bus.out_zero_l = s3_res_r.zero_l;
  assign bus.out_uf_h   = s3_res_r.uf_h;
  assign bus.out_uf_l   = s3_res_r.uf_l;
`else
  assign ld2_s      = !s2_valid_r | bus.out_ready;
  assign in_ready_s = ld1_s;

  assign bus.out_valid  = s2_valid_r;
  assign bus.out_fmt    = s2_res_r.fmt;
  assign bus.out_r      = s2_res_r.r;
  assign bus.out_e_h    = s2_res_r.e_h;
  assign bus.out_e_l    = s2_res_r.e_l;
  assign bus.out_zero_h = s2_res_r.zero_h;
  assign bus.out_zero_l = s2_res_r.zero_l;
  assign bus.out_uf_h   = s2_res_r.uf_h;
  assign bus.out_uf_l   = s2_res_r.uf_l;
`endif

  assign ld1_s        = !s1_valid_r | ld2_s;
  assign accept_s     = bus.in_valid & in_ready_s;
  assign bus.in_ready = in_ready_s;

  // Stage 1 captures the beat and lane counts; stage 2 captures the shifted result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_beat_r  <= '0;
      s1_lz_h_r  <= 5'd0;
      s1_lz_l_r  <= 5'd0;
      s2_valid_r <= 1'b0;
      s2_res_r   <= '0;
    end else begin
      if (ld1_s) begin
        s1_valid_r <= accept_s;
        s1_beat_r  <= in_beat_s;
        s1_lz_h_r  <= lz_h_s;
        s1_lz_l_r  <= lz_l_s;
      end
      if (ld2_s) begin
        s2_valid_r <= s1_valid_r;
        s2_res_r   <= res_s;
      end
    end
  end

endmodule

// File: tb/tb_fp_normalizer.sv
// Directed self-checking bench for fp_normalizer: single vectors, backpressure
// ordering and mid-stream reset.
module tb_fp_normalizer;
  import fpall_pkg::*;

`ifdef FPNORM_OUT_SKID_EN
  localparam int LAT = 3;
  localparam int CAP = 3;
`else
  localparam int LAT = 2;
  localparam int CAP = 2;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  fp_normalizer_if bus ();

  fp_normalizer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input fp_fmt_e fmt, input logic [25:0] x,
                       input logic [7:0] eh, input logic [7:0] el);
    bus.in_valid = 1'b1;
    bus.in_fmt   = fmt;
    bus.in_x     = x;
    bus.in_e_h   = eh;
    bus.in_e_l   = el;
  endtask

  // Enter at posedge+1 with an empty pipe and out_ready=1; leave at posedge+1.
  task automatic run_vec(input string tag, input fp_fmt_e fmt, input logic [25:0] x,
                         input logic [7:0] eh, input logic [7:0] el,
                         input logic [25:0] er, input logic [7:0] eeh,
                         input logic [7:0] eel, input logic [3:0] eflags);
    int lat;
    drive(fmt, x, eh, el);
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.out_valid) break;
      lat++;
      @(posedge clk);
      #1;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(LAT));
    chk({tag, "_r"}, 32'(bus.out_r), 32'(er));
    chk({tag, "_eh"}, 32'(bus.out_e_h), 32'(eeh));
    chk({tag, "_el"}, 32'(bus.out_e_l), 32'(eel));
    chk({tag, "_flags"},
        32'({bus.out_zero_h, bus.out_zero_l, bus.out_uf_h, bus.out_uf_l}), 32'(eflags));
    chk({tag, "_fmt"}, 32'(bus.out_fmt), 32'(fmt));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        rdy;
    logic [25:0] gx;
    int          sent;
    int          rcv;
    int          stale;

    bus.in_valid  = 1'b0;
    bus.in_fmt    = FP_FMT_FP32;
    bus.in_x      = 26'd0;
    bus.in_e_h    = 8'd0;
    bus.in_e_l    = 8'd0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_r", 32'(bus.out_r), 32'd0);
    chk("rst_e", 32'({bus.out_e_h, bus.out_e_l}), 32'd0);
    chk("rst_flags", 32'({bus.out_zero_h, bus.out_zero_l, bus.out_uf_h, bus.out_uf_l}), 32'd0);
    chk("rst_fmt", 32'(bus.out_fmt), 32'(FP_FMT_FP32));
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;

    // flags order: {zero_h, zero_l, uf_h, uf_l}
    run_vec("fp32_norm",   FP_FMT_FP32, 26'h0000100, 8'd0,  8'd100, 26'h2000000, 8'd0,  8'd83,  4'b0000);
    run_vec("fp32_zero",   FP_FMT_FP32, 26'h0000000, 8'd0,  8'd77,  26'h0000000, 8'd0,  8'd0,   4'b0100);
    run_vec("fp32_uf",     FP_FMT_FP32, 26'h0000100, 8'd0,  8'd5,   26'h0001000, 8'd0,  8'd0,   4'b0001);
    run_vec("fp16_dual",   FP_FMT_FP16, 26'h001FCC0, 8'd20, 8'd3,   26'h2000300, 8'd11, 8'd1,   4'b0000);
    run_vec("fp32_lz0",    FP_FMT_FP32, 26'h3FFFFFF, 8'd0,  8'd1,   26'h3FFFFFF, 8'd0,  8'd1,   4'b0000);
    run_vec("fp32_e_eq",   FP_FMT_FP32, 26'h0000001, 8'd0,  8'd25,  26'h1000000, 8'd0,  8'd0,   4'b0001);
    run_vec("fp32_e0",     FP_FMT_FP32, 26'h0000F00, 8'd0,  8'd0,   26'h0000F00, 8'd0,  8'd0,   4'b0001);
    run_vec("fp32_lz25",   FP_FMT_FP32, 26'h0000001, 8'd0,  8'd200, 26'h2000000, 8'd0,  8'd175, 4'b0000);
    run_vec("fp16_hzero",  FP_FMT_FP16, 26'h00003FF, 8'd9,  8'd1,   26'h00003FF, 8'd0,  8'd1,   4'b1000);
    run_vec("fp16_uf2",    FP_FMT_FP16, 26'h0045401, 8'd0,  8'd4,   26'h0040008, 8'd0,  8'd0,   4'b0011);

    // Backpressure: 4 beats offered while the output stalls for 5 cycles.
    sent = 0;
    rcv  = 0;
    for (int cyc = 0; cyc < 40 && rcv < 4; cyc++) begin
      bus.out_ready = (cyc >= 5);
      if (sent < 4) begin
        gx = 26'd1 << (sent * 3);
        drive(FP_FMT_FP32, gx, 8'd0, 8'd100);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      rdy = bus.in_ready;
      if (cyc == 4) begin
        chk("bp_stall_rdy", 32'(rdy), 32'd0);
        chk("bp_cap", 32'(sent), 32'(CAP));
        chk("bp_stall_valid", 32'(bus.out_valid), 32'd1);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("bp_r%0d", rcv), 32'(bus.out_r), 32'h2000000);
        chk($sformatf("bp_e%0d", rcv), 32'(bus.out_e_l), 32'(75 + 3 * rcv));
        rcv++;
      end
      if (bus.in_valid && rdy) sent++;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("bp_count", 32'(rcv), 32'd4);
    repeat (4) @(posedge clk);
    #1;

    // Reset while two beats are in flight and a third is being offered.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(FP_FMT_FP32, 26'h3 << k, 8'd0, 8'd50);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    drive(FP_FMT_FP32, 26'h7, 8'd0, 8'd50);
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rstm_valid", 32'(bus.out_valid), 32'd0);
    chk("rstm_ready", 32'(bus.in_ready), 32'd1);
    chk("rstm_r", 32'(bus.out_r), 32'd0);
    chk("rstm_el", 32'(bus.out_e_l), 32'd0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    stale = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
      @(posedge clk);
      #1;
    end
    chk("rstm_stale", 32'(stale), 32'd0);

    run_vec("post_rst", FP_FMT_FP32, 26'h0000100, 8'd0, 8'd100, 26'h2000000, 8'd0, 8'd83, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
